// File: rtl/vec_add_cmd_splitter_pkg.sv
// Shared types for the vector-add command splitter: FSM state, widths and
// the command payload carried both in the latch and on the cmd_0 port.
package vec_add_cmd_splitter_pkg;

    localparam int ADDR_W = 32;
    localparam int LEN_W  = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] vec_a_addr;
        logic [ADDR_W-1:0] vec_b_addr;
        logic [ADDR_W-1:0] vec_out_addr;
        logic [LEN_W-1:0]  vector_length;
    } cmd_t;

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/vec_add_cmd_splitter.sv
// Splits one vector-add command into <=MAX_CHUNK sub-commands, one in flight, single upstream response.
// One cycle per FSM hop; valids hold until handshake. Optional counters: VEC_ADD_CMD_SPLITTER_STATS_EN.
module vec_add_cmd_splitter
    import vec_add_cmd_splitter_pkg::*;
#(
    parameter int MAX_CHUNK  = 1024,
    parameter int ELEM_BYTES = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_cmd_valid,
    output logic              in_cmd_ready,
    input  logic [ADDR_W-1:0] in_cmd_vec_a_addr,
    input  logic [ADDR_W-1:0] in_cmd_vec_b_addr,
    input  logic [ADDR_W-1:0] in_cmd_vec_out_addr,
    input  logic [LEN_W-1:0]  in_cmd_vector_length,
    output logic              in_resp_valid,
    input  logic              in_resp_ready,
    output logic              cmd_0_valid,
    input  logic              cmd_0_ready,
    output logic [ADDR_W-1:0] cmd_0_vec_a_addr,
    output logic [ADDR_W-1:0] cmd_0_vec_b_addr,
    output logic [ADDR_W-1:0] cmd_0_vec_out_addr,
    output logic [LEN_W-1:0]  cmd_0_vector_length,
    input  logic              resp_0_valid,
    output logic              resp_0_ready
`ifdef VEC_ADD_CMD_SPLITTER_STATS_EN
    ,
    output logic [31:0]       stat_chunks,
    output logic [31:0]       stat_busy_cycles
`endif
);

    localparam logic [LEN_W-1:0] MAX_CHUNK_L = LEN_W'(MAX_CHUNK);

    state_t           state;
    cmd_t             cur;   // cursor addresses; vector_length holds elements remaining
    logic [LEN_W-1:0] chunk;
    logic [LEN_W-1:0] chunk_bytes;

    assign chunk = (cur.vector_length > MAX_CHUNK_L) ? MAX_CHUNK_L : cur.vector_length;

    generate
        if (is_pow2(ELEM_BYTES)) begin : g_shift
            assign chunk_bytes = chunk << $clog2(ELEM_BYTES);
        end else begin : g_mul
            assign chunk_bytes = chunk * LEN_W'(ELEM_BYTES);
        end
    endgenerate

    assign cmd_0_vec_a_addr    = cur.vec_a_addr;
    assign cmd_0_vec_b_addr    = cur.vec_b_addr;
    assign cmd_0_vec_out_addr  = cur.vec_out_addr;
    assign cmd_0_vector_length = chunk;

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            cur           <= '0;
            in_cmd_ready  <= 1'b0;
            in_resp_valid <= 1'b0;
            cmd_0_valid   <= 1'b0;
            resp_0_ready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_cmd_ready <= 1'b1;
                    if (in_cmd_valid && in_cmd_ready) begin
                        cur <= '{vec_a_addr:    in_cmd_vec_a_addr,
                                 vec_b_addr:    in_cmd_vec_b_addr,
                                 vec_out_addr:  in_cmd_vec_out_addr,
                                 vector_length: in_cmd_vector_length};
                        in_cmd_ready <= 1'b0;
                        if (in_cmd_vector_length == '0) begin
                            state         <= RESP;
                            in_resp_valid <= 1'b1;
                        end else begin
                            state       <= ISSUE;
                            cmd_0_valid <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (cmd_0_valid && cmd_0_ready) begin
                        state        <= WAIT;
                        cmd_0_valid  <= 1'b0;
                        resp_0_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    if (resp_0_valid && resp_0_ready) begin
                        resp_0_ready          <= 1'b0;
                        cur.vec_a_addr        <= cur.vec_a_addr + chunk_bytes;
                        cur.vec_b_addr        <= cur.vec_b_addr + chunk_bytes;
                        cur.vec_out_addr      <= cur.vec_out_addr + chunk_bytes;
                        cur.vector_length     <= cur.vector_length - chunk;
                        if (cur.vector_length == chunk) begin
                            state         <= RESP;
                            in_resp_valid <= 1'b1;
                        end else begin
                            state       <= ISSUE;
                            cmd_0_valid <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (in_resp_valid && in_resp_ready) begin
                        state         <= IDLE;
                        in_resp_valid <= 1'b0;
                        in_cmd_ready  <= 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    in_cmd_ready  <= 1'b0;
                    in_resp_valid <= 1'b0;
                    cmd_0_valid   <= 1'b0;
                    resp_0_ready  <= 1'b0;
                end
            endcase
        end
    end

`ifdef VEC_ADD_CMD_SPLITTER_STATS_EN
    // Busy count covers every non-IDLE cycle, so it stops on its own after the response handshake.
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_chunks      <= '0;
            stat_busy_cycles <= '0;
        end else begin
            if (cmd_0_valid && cmd_0_ready && (stat_chunks != 32'hFFFF_FFFF))
                stat_chunks <= stat_chunks + 32'd1;
            if (state == IDLE) begin
                if (in_cmd_valid && in_cmd_ready)
                    stat_busy_cycles <= '0;
            end else begin
                stat_busy_cycles <= stat_busy_cycles + 32'd1;
            end
        end
    end
`endif

endmodule
